// File: rtl/seg16_disp_arbiter.sv
// Two-writer arbiter for the 16-digit display: two pages of four words, round-robin
// grants between CPU and debug, debug lock with drop counting, and timed page rotation.
module seg16_disp_arbiter #(
  parameter int unsigned ROT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  input  logic        dbg_req,
  input  logic [3:0]  dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_ack,
  input  logic        dbg_lock,
  output logic [15:0] data_A,
  output logic [15:0] data_B,
  output logic [15:0] data_C,
  output logic [15:0] data_D,
  output logic        page,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned CntW = (ROT_CYCLES > 1) ? $clog2(ROT_CYCLES) : 1;
  localparam logic [CntW-1:0] RotMax = CntW'(ROT_CYCLES - 1);
  localparam logic [3:0] CtrlAddr = 4'd8;

  logic [15:0]     slot_q [8];
  logic            page_q;
  logic            auto_q;
  logic [CntW-1:0] rot_cnt_q;
  logic            cpu_ack_q;
  logic            dbg_ack_q;
  logic [7:0]      drop_q;
  // High when debug held the most recent grant, so the CPU wins the next contest.
  logic            rr_dbg_last_q;

  logic        cpu_elig;
  logic        dbg_elig;
  logic        gnt_cpu;
  logic        gnt_dbg;
  logic        wr_en;
  logic        drop_inc;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;

  always_comb begin
    cpu_elig = cpu_req & ~cpu_ack_q;
    dbg_elig = dbg_req & ~dbg_ack_q;
    gnt_cpu  = cpu_elig & (~dbg_elig | rr_dbg_last_q);
    gnt_dbg  = dbg_elig & ~gnt_cpu;
    wr_addr  = gnt_dbg ? dbg_addr  : cpu_addr;
    wr_data  = gnt_dbg ? dbg_wdata : cpu_wdata;
    wr_en    = gnt_dbg | (gnt_cpu & ~dbg_lock);
    drop_inc = gnt_cpu & dbg_lock;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        slot_q[i] <= 16'h0000;
      end
      page_q        <= 1'b0;
      auto_q        <= 1'b0;
      rot_cnt_q     <= '0;
      cpu_ack_q     <= 1'b0;
      dbg_ack_q     <= 1'b0;
      drop_q        <= 8'd0;
      rr_dbg_last_q <= 1'b1;
    end else begin
      cpu_ack_q <= gnt_cpu;
      dbg_ack_q <= gnt_dbg;
      if (gnt_cpu || gnt_dbg) begin
        rr_dbg_last_q <= gnt_dbg;
      end
      if (drop_inc && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end

      if (auto_q) begin
        if (rot_cnt_q == RotMax) begin
          rot_cnt_q <= '0;
          page_q    <= ~page_q;
        end else begin
          rot_cnt_q <= rot_cnt_q + 1'b1;
        end
      end else begin
        rot_cnt_q <= '0;
      end

      // Placed after the rotate logic so a ctrl write overrides a coincident wrap.
      if (wr_en) begin
        if (!wr_addr[3]) begin
          slot_q[wr_addr[2:0]] <= wr_data;
        end else if (wr_addr == CtrlAddr) begin
          page_q    <= wr_data[0];
          auto_q    <= wr_data[1];
          rot_cnt_q <= '0;
        end
      end
    end
  end

  assign data_A   = slot_q[{page_q, 2'd0}];
  assign data_B   = slot_q[{page_q, 2'd1}];
  assign data_C   = slot_q[{page_q, 2'd2}];
  assign data_D   = slot_q[{page_q, 2'd3}];
  assign page     = page_q;
  assign drop_cnt = drop_q;
  assign cpu_ack  = cpu_ack_q;
  assign dbg_ack  = dbg_ack_q;

endmodule

// File: tb/tb_seg16_disp_arbiter.sv
// Directed bench for seg16_disp_arbiter: table of single writes plus hand sequences for
// contests, lock timing, drop saturation, auto-rotate and mid-operation reset.
module tb_seg16_disp_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic [3:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic        dbg_req;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_wdata;
  logic        dbg_ack;
  logic        dbg_lock;
  logic [15:0] data_A, data_B, data_C, data_D;
  logic        page;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  seg16_disp_arbiter #(.ROT_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .dbg_req   (dbg_req),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_lock  (dbg_lock),
    .data_A    (data_A),
    .data_B    (data_B),
    .data_C    (data_C),
    .data_D    (data_D),
    .page      (page),
    .drop_cnt  (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit          is_dbg;
    bit          lock;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] ea, eb, ec, ed;
    bit          epage;
    logic [7:0]  edrop;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%h req=%h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                            input logic [15:0] ec, input logic [15:0] ed, input bit ep,
                            input logic [7:0] edr);
    check({tag, "_A"}, data_A, ea);
    check({tag, "_B"}, data_B, eb);
    check({tag, "_C"}, data_C, ec);
    check({tag, "_D"}, data_D, ed);
    check({tag, "_page"}, page, ep);
    check({tag, "_drop"}, drop_cnt, edr);
  endtask

  // Called at a negedge; returns at the negedge of the ack cycle with req dropped.
  task automatic do_write(input bit is_dbg, input logic [3:0] a, input logic [15:0] d,
                          output int lat);
    logic seen;
    seen = 1'b0;
    lat  = 0;
    if (is_dbg) begin
      dbg_req = 1'b1; dbg_addr = a; dbg_wdata = d;
    end else begin
      cpu_req = 1'b1; cpu_addr = a; cpu_wdata = d;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      lat++;
      seen = is_dbg ? dbg_ack : cpu_ack;
      if (seen) break;
    end
    if (!seen) lat = 99;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask

  task automatic contest(input string tag, input logic [15:0] cd, input logic [15:0] dd);
    cpu_req = 1'b1; cpu_addr = 4'd1; cpu_wdata = cd;
    dbg_req = 1'b1; dbg_addr = 4'd1; dbg_wdata = dd;
    @(negedge clk);
    check({tag, "_cpu_ack_first"}, cpu_ack, 1'b1);
    check({tag, "_dbg_waits"}, dbg_ack, 1'b0);
    check({tag, "_B_cpu"}, data_B, cd);
    cpu_req = 1'b0;
    @(negedge clk);
    check({tag, "_dbg_ack_second"}, dbg_ack, 1'b1);
    check({tag, "_cpu_ack_low"}, cpu_ack, 1'b0);
    check({tag, "_B_dbg"}, data_B, dd);
    dbg_req = 1'b0;
    @(negedge clk);
    check({tag, "_acks_idle"}, {cpu_ack, dbg_ack}, 2'b00);
  endtask

  initial begin
    int lat;
    int max_lat;

    vecs[0]  = '{0, 0, 4'h0, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 8'd0};
    vecs[1]  = '{1, 0, 4'h3, 16'h0F0F, 16'h1234, 16'h0000, 16'h0000, 16'h0F0F, 0, 8'd0};
    vecs[2]  = '{0, 0, 4'h4, 16'h0004, 16'h1234, 16'h0000, 16'h0000, 16'h0F0F, 0, 8'd0};
    vecs[3]  = '{0, 0, 4'h8, 16'hFFF1, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 1, 8'd0};
    vecs[4]  = '{1, 0, 4'h7, 16'h7777, 16'h0004, 16'h0000, 16'h0000, 16'h7777, 1, 8'd0};
    vecs[5]  = '{0, 0, 4'h8, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'h0F0F, 0, 8'd0};
    vecs[6]  = '{0, 0, 4'h9, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 16'h0F0F, 0, 8'd0};
    vecs[7]  = '{0, 1, 4'h2, 16'hDEAD, 16'h1234, 16'h0000, 16'h0000, 16'h0F0F, 0, 8'd1};
    vecs[8]  = '{0, 1, 4'h8, 16'h0001, 16'h1234, 16'h0000, 16'h0000, 16'h0F0F, 0, 8'd2};
    vecs[9]  = '{1, 1, 4'h2, 16'h0BAD, 16'h1234, 16'h0000, 16'h0BAD, 16'h0F0F, 0, 8'd2};
    vecs[10] = '{1, 0, 4'hC, 16'h1111, 16'h1234, 16'h0000, 16'h0BAD, 16'h0F0F, 0, 8'd2};

    rst = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
    cpu_addr = 4'd0; cpu_wdata = 16'h0; dbg_addr = 4'd0; dbg_wdata = 16'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_outs("reset", 16'h0, 16'h0, 16'h0, 16'h0, 0, 8'd0);
    check("reset_acks", {cpu_ack, dbg_ack}, 2'b00);

    foreach (vecs[i]) begin
      dbg_lock = vecs[i].lock;
      do_write(vecs[i].is_dbg, vecs[i].addr, vecs[i].wdata, lat);
      check($sformatf("vec%0d_latency", i), lat, 1);
      check_outs($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ed,
                 vecs[i].epage, vecs[i].edrop);
      @(negedge clk);
      check($sformatf("vec%0d_ack_one_cycle", i), {cpu_ack, dbg_ack}, 2'b00);
      dbg_lock = 1'b0;
    end

    contest("contest1", 16'hAAAA, 16'h5555);
    contest("contest2", 16'h1357, 16'h2468);

    // Lock rising in the ack cycle, with req still held, must not drop or re-grant.
    cpu_req = 1'b1; cpu_addr = 4'd0; cpu_wdata = 16'h5A5A;
    @(negedge clk);
    check("lockrise_ack", cpu_ack, 1'b1);
    dbg_lock = 1'b1;
    @(negedge clk);
    cpu_req = 1'b0;
    check("lockrise_A", data_A, 16'h5A5A);
    check("lockrise_drop", drop_cnt, 8'd2);
    check("lockrise_no_regrant", cpu_ack, 1'b0);

    max_lat = 0;
    for (int i = 0; i < 300; i++) begin
      do_write(0, 4'd2, 16'hDEAD, lat);
      if (lat > max_lat) max_lat = lat;
      @(negedge clk);
    end
    check("sat_latency", max_lat, 1);
    check("sat_drop", drop_cnt, 8'd255);
    check("sat_C_kept", data_C, 16'h0BAD);
    do_write(1, 4'd2, 16'hBEEF, lat);
    check("dbg_locked_latency", lat, 1);
    check("dbg_locked_C", data_C, 16'hBEEF);
    check("dbg_locked_drop", drop_cnt, 8'd255);
    dbg_lock = 1'b0;
    @(negedge clk);

    do_write(0, 4'd8, 16'h0002, lat);
    check("rot_en_latency", lat, 1);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("rot_k%0d_page", k), page, ((k - 1) / 4) % 2);
      if (k < 8) @(negedge clk);
    end
    // This cycle is a wrap with page=1; the ctrl write must hold page at 1.
    do_write(0, 4'd8, 16'h0003, lat);
    check("rot_wrap_latency", lat, 1);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("rot_restart_k%0d_page", k), page, (k <= 4) ? 1 : 0);
      @(negedge clk);
    end
    do_write(0, 4'd8, 16'h0001, lat);
    check("pre_reset_page", page, 1'b1);
    @(negedge clk);

    rst = 1'b1;
    cpu_req = 1'b1; cpu_addr = 4'd0; cpu_wdata = 16'h9999;
    @(negedge clk);
    check_outs("midrst", 16'h0, 16'h0, 16'h0, 16'h0, 0, 8'd0);
    check("midrst_acks", {cpu_ack, dbg_ack}, 2'b00);
    rst = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check("midrst_no_late_ack", cpu_ack, 1'b0);
    check("midrst_A_unwritten", data_A, 16'h0000);

    contest("postrst", 16'h0101, 16'h0202);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg16_disp_arbiter.md
# seg16_disp_arbiter

Shares the 16-digit seven-segment display between two writers: the CPU MMIO port and the debug monitor port. It holds two pages of four 16-bit display words and arbitrates writes round-robin. It honours a debug lock and schedules page rotation. Its data_A..data_D outputs drive the 16-digit scanner's four 16-bit data inputs directly.

## Interface
- ROT_CYCLES, default 50_000_000: auto-rotate period in clk cycles, ≥2; counter width = clog2(ROT_CYCLES).
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- cpu_req  in  1  CPU write request; addr/wdata held stable until cpu_ack
- cpu_addr  in  4  CPU target register
- cpu_wdata  in  16  CPU write data
- cpu_ack  out  1  one-cycle registered acknowledge
- dbg_req  in  1  debug write request; same handshake
- dbg_addr  in  4  debug target register
- dbg_wdata  in  16  debug write data
- dbg_ack  out  1  one-cycle registered acknowledge
- dbg_lock  in  1  level; while high, CPU writes are discarded
- data_A, data_B, data_C, data_D  out  16 each  active-page words to the scanner
- page  out  1  active page index
- drop_cnt  out  8  saturating count of discarded CPU writes

## Operation
- Address map:
  - 0–3: page-0 slots feeding A, B, C, D.
  - 4–7: page-1 slots feeding A, B, C, D.
  - 8: ctrl. bit0 = page select, bit1 = auto-rotate enable; other bits ignored.
  - 9–15: acked, no effect, not counted as a drop.
- Eligibility: a requester is eligible when its req is high and its ack is low this cycle. The cycle in which ack is high never re-grants, so a held req is never written twice.
- Arbitration: at most one grant per cycle.
  - Single eligible requester: it wins.
  - Both eligible: grant goes to the requester not granted last. The rr pointer updates only on a contested or uncontested grant.
- Grant effect: at the granting edge the target register is written, unless the requester is the CPU and dbg_lock is high in the grant cycle. The ack is registered high for the next cycle.
- Lock: a CPU grant while dbg_lock is high (ctrl included) is still acked. The write is discarded and drop_cnt increments, saturating at 255. Debug writes are never blocked.
- Outputs: data_A..D = slot[{page,0..3}] as a combinational mux of registered slots. page = ctrl.bit0.
- Auto-rotate, ctrl.bit1 = 1:
  - rot_cnt counts 0..ROT_CYCLES-1.
  - On the wrap edge page toggles and rot_cnt returns to 0.
  - With ctrl.bit1 = 0, rot_cnt holds 0.
- A ctrl write loads both bits and clears rot_cnt. If it coincides with a rotate wrap, the ctrl write wins: page = written bit0.

## Timing
- Reset values: all 8 slots 0; page 0; auto 0; rot_cnt 0; cpu_ack and dbg_ack 0; drop_cnt 0; rr pointer = debug-last, so the CPU wins the first contest.
- Write latency:
  - req high in cycle N with grant → register updated at the end-of-N edge.
  - ack high in cycle N+1.
  - The new value is visible on data_X in N+1 if its page is active.
- Throughput: one write per 2 cycles per requester; one write per cycle total when both alternate.
- A contested loser waits, with req held, until the next cycle it is eligible.
- Page change from a ctrl write or a rotate wrap is visible on data_X and page the cycle after the edge.
- dbg_lock is sampled in the grant cycle only. A lock rising during the ack cycle does not retroactively drop the write.
- Reset mid-operation: rst dominates all updates. An in-flight request granted in the rst cycle is neither written nor acked; the requester re-issues.
- Requester dropping req before ack is a protocol violation with undefined result. The bench does not drive it.

## Test plan
- Reset, then CPU writes addr 0 = 16'h1234 → cpu_ack high exactly 1 cycle later; data_A = 16'h1234 in the ack cycle; page 0; drop_cnt 0.
- Both requesters assert the same cycle:
  - CPU addr 1 = 16'hAAAA, dbg addr 1 = 16'h5555.
  - Required: CPU is acked first, debug one cycle later, final data_B = 16'h5555.
  - Repeat the contest: debug is now last-granted, so the CPU wins again.
- dbg_lock = 1, CPU writes addr 2 = 16'hDEAD → acked; data_C unchanged. 300 such writes → drop_cnt = 255. A debug write to addr 2 = 16'hBEEF still lands.
- Paging:
  - Write slot 4 = 16'h0004, then ctrl = 2'b01 → data_A = 16'h0004, page = 1.
  - Then ctrl = 2'b00 → data_A shows the slot-0 value.
- ROT_CYCLES = 4, ctrl = 2'b10 → page toggles every 4 cycles after the write.
  - ctrl = 2'b11 issued on a wrap cycle → page = 1 and rot_cnt restarts at 0.
- Assert rst while a cpu_req is pending and granted → no ack; slot unchanged; all outputs at reset values the next cycle.
